// File: rtl/yinelemeli_bolucu.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow resolve in a single cycle.
module yinelemeli_bolucu #(
    parameter int unsigned VERI_GENISLIK = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     basla_i,
    input  logic [VERI_GENISLIK-1:0] bolunen_i,
    input  logic [VERI_GENISLIK-1:0] bolen_i,
    input  logic                     isaretli_i,
    input  logic                     iptal_i,
    output logic                     mesgul_o,
    output logic                     hazir_o,
    output logic [VERI_GENISLIK-1:0] bolum_o,
    output logic [VERI_GENISLIK-1:0] kalan_o
);

    localparam int unsigned W  = VERI_GENISLIK;
    localparam int unsigned SW = (W > 1) ? $clog2(W) : 1;
    localparam logic [W-1:0] EnNegatif = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {StBosta, StHesapla, StIsaret, StBitti} durum_e;

    durum_e         durum_q, durum_d;
    logic [SW-1:0]  sayac_q, sayac_d;
    logic [W-1:0]   q_q, q_d;
    logic [W-1:0]   d_q, d_d;
    logic [W:0]     r_q, r_d;
    logic           neg_bolum_q, neg_bolum_d;
    logic           neg_kalan_q, neg_kalan_d;
    logic [W-1:0]   bolum_q, bolum_d;
    logic [W-1:0]   kalan_q, kalan_d;

    logic [W-1:0]   bolunen_mut, bolen_mut;
    logic           sifira_bolme, tasma;
    logic [W:0]     kaydir;
    logic [W+1:0]   fark;

    assign bolunen_mut  = (isaretli_i && bolunen_i[W-1]) ? -bolunen_i : bolunen_i;
    assign bolen_mut    = (isaretli_i && bolen_i[W-1]) ? -bolen_i : bolen_i;
    assign sifira_bolme = (bolen_i == '0);
    assign tasma        = isaretli_i && (bolunen_i == EnNegatif) && (bolen_i == '1);

    // Shift next dividend bit into the partial remainder, then trial-subtract.
    assign kaydir = {r_q[W-1:0], q_q[W-1]};
    assign fark   = {1'b0, kaydir} - {2'b00, d_q};

    always_comb begin
        durum_d     = durum_q;
        sayac_d     = sayac_q;
        q_d         = q_q;
        d_d         = d_q;
        r_d         = r_q;
        neg_bolum_d = neg_bolum_q;
        neg_kalan_d = neg_kalan_q;
        bolum_d     = bolum_q;
        kalan_d     = kalan_q;

        if (iptal_i) begin
            durum_d = StBosta;
        end else begin
            unique case (durum_q)
                StBosta, StBitti: begin
                    if (basla_i) begin
                        if (sifira_bolme) begin
                            bolum_d = '1;
                            kalan_d = bolunen_i;
                            durum_d = StBitti;
                        end else if (tasma) begin
                            bolum_d = bolunen_i;
                            kalan_d = '0;
                            durum_d = StBitti;
                        end else begin
                            q_d         = bolunen_mut;
                            d_d         = bolen_mut;
                            r_d         = '0;
                            neg_bolum_d = isaretli_i && (bolunen_i[W-1] ^ bolen_i[W-1]);
                            neg_kalan_d = isaretli_i && bolunen_i[W-1];
                            sayac_d     = SW'(W - 1);
                            durum_d     = StHesapla;
                        end
                    end
                end
                StHesapla: begin
                    if (!fark[W+1]) begin
                        r_d = fark[W:0];
                        q_d = {q_q[W-2:0], 1'b1};
                    end else begin
                        r_d = kaydir;
                        q_d = {q_q[W-2:0], 1'b0};
                    end
                    if (sayac_q == '0) begin
                        durum_d = StIsaret;
                    end else begin
                        sayac_d = sayac_q - 1'b1;
                    end
                end
                StIsaret: begin
                    bolum_d = neg_bolum_q ? -q_q : q_q;
                    kalan_d = neg_kalan_q ? -r_q[W-1:0] : r_q[W-1:0];
                    durum_d = StBitti;
                end
                default: durum_d = StBosta;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum_q     <= StBosta;
            sayac_q     <= '0;
            q_q         <= '0;
            d_q         <= '0;
            r_q         <= '0;
            neg_bolum_q <= 1'b0;
            neg_kalan_q <= 1'b0;
            bolum_q     <= '0;
            kalan_q     <= '0;
        end else begin
            durum_q     <= durum_d;
            sayac_q     <= sayac_d;
            q_q         <= q_d;
            d_q         <= d_d;
            r_q         <= r_d;
            neg_bolum_q <= neg_bolum_d;
            neg_kalan_q <= neg_kalan_d;
            bolum_q     <= bolum_d;
            kalan_q     <= kalan_d;
        end
    end

    assign mesgul_o = (durum_q == StHesapla) || (durum_q == StIsaret);
    assign hazir_o  = (durum_q == StBitti);
    assign bolum_o  = bolum_q;
    assign kalan_o  = kalan_q;

endmodule

// File: tb/tb_yinelemeli_bolucu.sv
// Self-checking bench for yinelemeli_bolucu: directed corner cases plus randomised
// operands against an arithmetic reference model.
module tb_yinelemeli_bolucu;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        basla_i;
    logic [31:0] bolunen_i;
    logic [31:0] bolen_i;
    logic        isaretli_i;
    logic        iptal_i;
    logic        mesgul_o;
    logic        hazir_o;
    logic [31:0] bolum_o;
    logic [31:0] kalan_o;

    int kontrol_sayisi = 0;
    int hata_sayisi    = 0;
    logic [31:0] son_bolum = '0;
    logic [31:0] son_kalan = '0;

    yinelemeli_bolucu #(.VERI_GENISLIK(32)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .basla_i    (basla_i),
        .bolunen_i  (bolunen_i),
        .bolen_i    (bolen_i),
        .isaretli_i (isaretli_i),
        .iptal_i    (iptal_i),
        .mesgul_o   (mesgul_o),
        .hazir_o    (hazir_o),
        .bolum_o    (bolum_o),
        .kalan_o    (kalan_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                           input logic [31:0] beklenen);
        kontrol_sayisi++;
        if (gozlenen !== beklenen) begin
            hata_sayisi++;
            $display("FAIL %s: gozlenen=%h beklenen=%h", etiket, gozlenen, beklenen);
        end
    endtask

    // RISC-V division semantics in plain arithmetic.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] q, output logic [31:0] r, output int gecikme);
        longint sa, sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            gecikme = 1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 32'd0;
            gecikme = 1;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = 32'(sa / sb);
            r = 32'(sa % sb);
            gecikme = 34;
        end else begin
            q = a / b;
            r = a % b;
            gecikme = 34;
        end
    endtask

    function automatic logic [31:0] kenar_deger();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Presents an operation for one cycle; returns at the negedge of cycle 1.
    task automatic baslat(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk_i);
        basla_i    = 1'b1;
        bolunen_i  = a;
        bolen_i    = b;
        isaretli_i = s;
        @(negedge clk_i);
        basla_i    = 1'b0;
        bolunen_i  = $urandom;
        bolen_i    = $urandom;
        isaretli_i = 1'($urandom);
    endtask

    // Waits for hazir_o starting at cycle n0 after accept, then checks latency, busy span,
    // results and that the result is held one more cycle.
    task automatic bekle(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int n0, input string etiket);
        logic [31:0] bq, br;
        int gecikme, n, mesgul_say;
        model(a, b, s, bq, br, gecikme);
        n = n0;
        mesgul_say = 0;
        while (!hazir_o && n < 200) begin
            if (mesgul_o) mesgul_say++;
            @(negedge clk_i);
            n++;
        end
        kontrol({etiket, " gecikme"}, 32'(n), 32'(gecikme));
        kontrol({etiket, " mesgul"}, 32'(mesgul_say), 32'(gecikme - n0));
        kontrol({etiket, " bolum"}, bolum_o, bq);
        kontrol({etiket, " kalan"}, kalan_o, br);
        @(negedge clk_i);
        kontrol({etiket, " tutma hazir"}, 32'(hazir_o), 32'd1);
        kontrol({etiket, " tutma bolum"}, bolum_o, bq);
        son_bolum = bq;
        son_kalan = br;
    endtask

    task automatic islem(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input string etiket);
        baslat(a, b, s);
        bekle(a, b, s, 1, etiket);
    endtask

    initial begin
        rst_i = 1'b1; basla_i = 1'b0; iptal_i = 1'b0;
        bolunen_i = '0; bolen_i = '0; isaretli_i = 1'b0;
        repeat (3) @(negedge clk_i);
        kontrol("reset hazir", 32'(hazir_o), 32'd0);
        kontrol("reset mesgul", 32'(mesgul_o), 32'd0);
        kontrol("reset bolum", bolum_o, 32'd0);
        kontrol("reset kalan", kalan_o, 32'd0);
        rst_i = 1'b0;

        islem(32'd100, 32'd7, 1'b1, "s100/7");
        kontrol("s100/7 sabit bolum", son_bolum, 32'd14);
        kontrol("s100/7 sabit kalan", son_kalan, 32'd2);
        islem(32'hFFFF_FFF9, 32'd2, 1'b1, "s-7/2");
        kontrol("s-7/2 sabit bolum", son_bolum, 32'hFFFF_FFFD);
        kontrol("s-7/2 sabit kalan", son_kalan, 32'hFFFF_FFFF);
        islem(32'hFFFF_FFFF, 32'h10, 1'b0, "uFFFFFFFF/16");
        kontrol("u sabit bolum", son_bolum, 32'h0FFF_FFFF);
        islem(32'd5, 32'd0, 1'b1, "s5/0");
        islem(32'd5, 32'd0, 1'b0, "u5/0");
        islem(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "tasma");
        islem(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "u80000000/-1");

        // Abort at cycle 10: outputs keep the previous result, no ready pulse.
        baslat(32'd100, 32'd7, 1'b1);
        repeat (9) @(negedge clk_i);
        iptal_i = 1'b1;
        @(negedge clk_i);
        iptal_i = 1'b0;
        kontrol("iptal mesgul", 32'(mesgul_o), 32'd0);
        kontrol("iptal hazir", 32'(hazir_o), 32'd0);
        kontrol("iptal bolum tut", bolum_o, son_bolum);
        kontrol("iptal kalan tut", kalan_o, son_kalan);
        islem(32'd9, 32'd3, 1'b0, "9/3 iptal sonrasi");

        // Abort beats start in the same cycle.
        @(negedge clk_i);
        basla_i = 1'b1; iptal_i = 1'b1; bolunen_i = 32'd8; bolen_i = 32'd2;
        @(negedge clk_i);
        basla_i = 1'b0; iptal_i = 1'b0;
        kontrol("iptal+basla mesgul", 32'(mesgul_o), 32'd0);
        kontrol("iptal+basla hazir", 32'(hazir_o), 32'd0);
        repeat (3) @(negedge clk_i);
        kontrol("iptal+basla sonra hazir", 32'(hazir_o), 32'd0);

        // Reset at cycle 20.
        baslat(32'd1234, 32'd11, 1'b0);
        repeat (19) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        kontrol("ara reset hazir", 32'(hazir_o), 32'd0);
        kontrol("ara reset mesgul", 32'(mesgul_o), 32'd0);
        kontrol("ara reset bolum", bolum_o, 32'd0);
        kontrol("ara reset kalan", kalan_o, 32'd0);
        rst_i = 1'b0;

        // Back-to-back start from the done state.
        islem(32'd50, 32'd5, 1'b0, "50/5");
        baslat(32'd1000, 32'd10, 1'b0);
        kontrol("ardisik hazir", 32'(hazir_o), 32'd0);
        bekle(32'd1000, 32'd10, 1'b0, 1, "1000/10");
        kontrol("1000/10 sabit", son_bolum, 32'd100);

        // Done state cleared by abort.
        @(negedge clk_i);
        iptal_i = 1'b1;
        @(negedge clk_i);
        iptal_i = 1'b0;
        kontrol("bitti iptal hazir", 32'(hazir_o), 32'd0);
        kontrol("bitti iptal bolum", bolum_o, 32'd100);

        // Start pulse while busy is ignored.
        baslat(32'hFFFF_FFB3, 32'd5, 1'b1);
        repeat (4) @(negedge clk_i);
        basla_i = 1'b1; bolunen_i = 32'd1; bolen_i = 32'd1;
        @(negedge clk_i);
        basla_i = 1'b0;
        bekle(32'hFFFF_FFB3, 32'd5, 1'b1, 6, "mesgulde basla");

        for (int i = 0; i < 150; i++) begin
            logic [31:0] a, b;
            logic s;
            a = kenar_deger();
            b = kenar_deger();
            s = 1'($urandom);
            islem(a, b, s, $sformatf("rastgele %0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", kontrol_sayisi, hata_sayisi);
        $finish;
    end

endmodule
